sr_flag_arbiter: RTL

Round-robin controller that shares a single set/reset flag (an SR latch) among N requesters. Each requester asks to set or clear the flag. The block serialises the requests, drives `s`/`r` pulses of a fixed width, and never asserts `s` and `r` together, so the latch's invalid state cannot occur. It sits between request-generating logic and the SR latch storage element and keeps a registered shadow copy of the flag.

---
 rtl/sr_flag_arbiter_pkg.sv | 6 +
 rtl/sr_flag_arbiter_if.sv | 7 +
 rtl/sr_flag_arbiter_rr_arbiter.sv | 24 ++
 rtl/sr_flag_arbiter.sv | 79 +++++++
 4 files changed

// File: rtl/sr_flag_arbiter_pkg.sv
// sr_ctrl_pkg: shared state encoding and operation constants for the SR flag arbiter
package sr_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, DRIVE, RECOVER} state_t;
    localparam logic OP_SET = 1'b1;
    localparam logic OP_RST = 1'b0;
endpackage

// File: rtl/sr_flag_arbiter_if.sv
// sr_flag_arbiter_if: request/grant and latch-drive bundle between requesters and the arbiter
interface sr_flag_arbiter_if #(parameter int N = 4);
    logic [N-1:0] req, op, gnt;
    logic s, r, done, busy, q;
    modport master (output req, op, input s, r, gnt, done, busy, q);
    modport slave (input req, op, output s, r, gnt, done, busy, q);
endinterface

// File: rtl/sr_flag_arbiter_rr_arbiter.sv
// rr_arbiter: picks the first requester at or after ptr, wrapping around
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  sel,
    output logic [IW-1:0] idx
);
    logic found;
    always_comb begin
        sel = '0;
        idx = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[(int'(ptr) + i) % N]) begin
                found = 1'b1;
                sel[(int'(ptr) + i) % N] = 1'b1;
                idx = IW'((int'(ptr) + i) % N);
            end
        end
    end
endmodule

// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter: serialises set/clear requests onto one SR latch with fixed-width, non-overlapping pulses
module sr_flag_arbiter
    import sr_ctrl_pkg::*;
#(
    parameter int N = 4,
    parameter int PULSE = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1,
    localparam int CW = $clog2(PULSE + 1)
) (
    input logic clk,
    input logic rst,
    sr_flag_arbiter_if.slave bus
);
    state_t state;
    logic [IW-1:0] ptr, idx_q, idx;
    logic [N-1:0] sel, gnt;
    logic [CW-1:0] cnt;
    logic op_q, op_sel, s, r, done, busy, q;
    assign op_sel = bus.op[idx];
    assign bus.s = s;
    assign bus.r = r;
    assign bus.gnt = gnt;
    assign bus.done = done;
    assign bus.busy = busy;
    assign bus.q = q;
    rr_arbiter #(.N(N)) u_arb (.req(bus.req), .ptr(ptr), .sel(sel), .idx(idx));
    // Async reset kills an in-flight pulse at once so the latch is never left half-driven
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr <= '0;
            idx_q <= '0;
            cnt <= '0;
            op_q <= 1'b0;
            gnt <= '0;
            s <= 1'b0;
            r <= 1'b0;
            done <= 1'b0;
            busy <= 1'b0;
            q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|bus.req) begin
                    gnt <= sel;
                    idx_q <= idx;
                    op_q <= op_sel;
                    busy <= 1'b1;
                    if (op_sel == q) begin
                        done <= 1'b1;
                        state <= RECOVER;
                    end else begin
                        s <= op_sel == OP_SET;
                        r <= op_sel == OP_RST;
                        cnt <= CW'(1);
                        state <= DRIVE;
                    end
                end
                DRIVE: if (cnt == CW'(PULSE)) begin
                    s <= 1'b0;
                    r <= 1'b0;
                    q <= op_q;
                    done <= 1'b1;
                    cnt <= '0;
                    state <= RECOVER;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                RECOVER: begin
                    gnt <= '0;
                    done <= 1'b0;
                    busy <= 1'b0;
                    ptr <= (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
